// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake plus the side-channel to the external 4-bit adder slice.
// The master side issues operands and models the slice; the slave side is the sequencer.
interface nibble_serial_adder_if #(parameter int NIBBLES = 4);
  localparam int W = 4*NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [4:0]   add_s;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, add_s, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, add_s, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial wide adder: steps an external 4-bit slice across the operands LSB nibble first,
// chaining the carry through a register, and presents the wide sum on valid/ready.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int            W    = 4*NIBBLES;
  localparam int            IW   = $clog2(NIBBLES) + 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic          r_out_valid;

  logic [3:0]    w_nib_a, w_nib_b;

  // Nibble select with constant part-selects keeps every operand bit observable.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib_a = r_a[4*i +: 4];
        w_nib_b = r_b[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.in_a;
            r_b     <= bus.in_b;
            r_carry <= bus.in_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (r_idx == IW'(i)) r_sum[4*i +: 4] <= bus.add_s[3:0];
          r_carry <= bus.add_s[4];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          // Return to IDLE only; a new request is taken on a later edge.
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.add_a     = (r_state == S_RUN) ? w_nib_a : 4'h0;
  assign bus.add_b     = (r_state == S_RUN) ? w_nib_b : 4'h0;
  assign bus.add_cin   = (r_state == S_RUN) ? r_carry : 1'b0;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_carry;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance, each with a
// behavioural adder slice, checked against plain wide-integer arithmetic.
module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1();

  assign bus4.add_s = {1'b0, bus4.add_a} + {1'b0, bus4.add_b} + {4'b0, bus4.add_cin};
  assign bus1.add_s = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {4'b0, bus1.add_cin};

  nibble_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  nibble_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  int errs = 0;
  int checks = 0;

  function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  // carry entering nibble k = carry out of the low 4*k bits of the full addition
  function automatic logic ref_carry(logic [W-1:0] a, logic [W-1:0] b, logic c, int k);
    longint unsigned m, s;
    m = (64'd1 << (4*k)) - 64'd1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return ((s >> (4*k)) & 64'd1) != 64'd0;
  endfunction

  function automatic logic [3:0] nib(logic [W-1:0] v, int k);
    return 4'((v >> (4*k)) & 16'hF);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus4.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", bus4.out_valid); end
    checks++; if (bus4.out_sum !== 16'h0) begin errs++; $display("FAIL reset_out_sum got %h exp 0000", bus4.out_sum); end
    checks++; if ({bus4.out_cout, bus4.busy, bus4.add_a, bus4.add_b, bus4.add_cin} !== 11'h0)
      begin errs++; $display("FAIL reset_misc got %h exp 000", {bus4.out_cout, bus4.busy, bus4.add_a, bus4.add_b, bus4.add_cin}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus4.in_ready !== 1'b1 || bus4.busy !== 1'b0)
      begin errs++; $display("FAIL reset_release in_ready/busy got %b%b exp 10", bus4.in_ready, bus4.busy); end
  endtask

  // Spec vectors: full ripple, and the 4/1 3/2 2/3 1/4 slice feed.
  task automatic test_vectors();
    logic [W-1:0] ta [2] = '{16'hFFFF, 16'h1234};
    logic [W-1:0] tb [2] = '{16'h0001, 16'h4321};
    logic         tc [2] = '{1'b0, 1'b1};
    logic [W-1:0] es [2] = '{16'h0000, 16'h5556};
    logic         ec [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      checks++; if (bus4.in_ready !== 1'b1) begin errs++; $display("FAIL vec%0d in_ready got %b exp 1", v, bus4.in_ready); end
      bus4.in_a = ta[v]; bus4.in_b = tb[v]; bus4.in_cin = tc[v]; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        checks++;
        if ({bus4.add_a, bus4.add_b, bus4.add_cin, bus4.out_valid, bus4.busy} !==
            {nib(ta[v], k), nib(tb[v], k), ref_carry(ta[v], tb[v], tc[v], k), 1'b0, 1'b1}) begin
          errs++;
          $display("FAIL vec%0d run%0d a/b/cin/ov/busy got %h/%h/%b/%b/%b exp %h/%h/%b/0/1", v, k,
                   bus4.add_a, bus4.add_b, bus4.add_cin, bus4.out_valid, bus4.busy,
                   nib(ta[v], k), nib(tb[v], k), ref_carry(ta[v], tb[v], tc[v], k));
        end
        @(posedge clk); #1;
      end
      checks++;
      if ({bus4.out_valid, bus4.out_cout, bus4.out_sum} !== {1'b1, ec[v], es[v]}) begin
        errs++;
        $display("FAIL vec%0d result ov/cout/sum got %b/%b/%h exp 1/%b/%h", v,
                 bus4.out_valid, bus4.out_cout, bus4.out_sum, ec[v], es[v]);
      end
      bus4.out_ready = 1'b1;
      @(posedge clk); #1;
      bus4.out_ready = 1'b0;
      checks++; if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1)
        begin errs++; $display("FAIL vec%0d after_handshake ov/ir got %b%b exp 01", v, bus4.out_valid, bus4.in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    logic [W:0]   e;
    a = 16'h9C3E; b = 16'h7A55;
    e = ref_add(a, b, 1'b1);
    bus4.in_a = a; bus4.in_b = b; bus4.in_cin = 1'b1; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    for (int h = 0; h < 5; h++) begin
      checks++;
      if ({bus4.out_valid, bus4.in_ready, bus4.busy, bus4.out_cout, bus4.out_sum} !== {3'b101, e}) begin
        errs++;
        $display("FAIL bp hold%0d ov/ir/busy/cout/sum got %b/%b/%b/%b/%h exp 1/0/1/%b/%h", h,
                 bus4.out_valid, bus4.in_ready, bus4.busy, bus4.out_cout, bus4.out_sum, e[W], e[W-1:0]);
      end
      @(posedge clk); #1;
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    checks++; if (bus4.out_valid !== 1'b0) begin errs++; $display("FAIL bp release out_valid got %b exp 0", bus4.out_valid); end
  endtask

  // Second request held from RUN through the DONE handshake: must not be taken
  // until the block is back in IDLE.
  task automatic test_ignore_during_run();
    logic [W-1:0] a1, b1, a2, b2;
    logic [W:0]   e1, e2;
    a1 = 16'h0F0F; b1 = 16'h1111; a2 = 16'hBEEF; b2 = 16'h4242;
    e1 = ref_add(a1, b1, 1'b0);
    e2 = ref_add(a2, b2, 1'b1);
    bus4.in_a = a1; bus4.in_b = b1; bus4.in_cin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    bus4.in_a = a2; bus4.in_b = b2; bus4.in_cin = 1'b1; bus4.in_valid = 1'b1;
    repeat (N-1) @(posedge clk);
    #1;
    checks++;
    if ({bus4.out_valid, bus4.in_ready, bus4.out_cout, bus4.out_sum} !== {2'b10, e1}) begin
      errs++;
      $display("FAIL ignore first ov/ir/cout/sum got %b/%b/%b/%h exp 1/0/%b/%h",
               bus4.out_valid, bus4.in_ready, bus4.out_cout, bus4.out_sum, e1[W], e1[W-1:0]);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    checks++; if (bus4.busy !== 1'b0 || bus4.in_ready !== 1'b1)
      begin errs++; $display("FAIL ignore no_same_cycle busy/ir got %b%b exp 01", bus4.busy, bus4.in_ready); end
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    checks++; if (bus4.busy !== 1'b1 || bus4.add_a !== nib(a2, 0))
      begin errs++; $display("FAIL ignore second_accept busy/add_a got %b/%h exp 1/%h", bus4.busy, bus4.add_a, nib(a2, 0)); end
    repeat (N) @(posedge clk);
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_cout, bus4.out_sum} !== {1'b1, e2}) begin
      errs++;
      $display("FAIL ignore second ov/cout/sum got %b/%b/%h exp 1/%b/%h",
               bus4.out_valid, bus4.out_cout, bus4.out_sum, e2[W], e2[W-1:0]);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int pulses;
    bus4.in_a = 16'hABCD; bus4.in_b = 16'h1357; bus4.in_cin = 1'b1; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.out_valid, bus4.out_cout, bus4.busy, bus4.add_a, bus4.add_b, bus4.add_cin, bus4.out_sum} !== 28'h0) begin
      errs++;
      $display("FAIL midrst outputs ov/cout/busy/a/b/cin/sum got %b/%b/%b/%h/%h/%b/%h exp all 0",
               bus4.out_valid, bus4.out_cout, bus4.busy, bus4.add_a, bus4.add_b, bus4.add_cin, bus4.out_sum);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus4.in_ready !== 1'b1) begin errs++; $display("FAIL midrst in_ready got %b exp 1", bus4.in_ready); end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus4.out_valid !== 1'b0) pulses++;
      @(posedge clk); #1;
    end
    checks++; if (pulses != 0) begin errs++; $display("FAIL midrst out_valid_pulses got %0d exp 0", pulses); end
  endtask

  task automatic test_single_nibble();
    checks++; if (bus1.in_ready !== 1'b1) begin errs++; $display("FAIL n1 in_ready got %b exp 1", bus1.in_ready); end
    bus1.in_a = 4'hF; bus1.in_b = 4'hF; bus1.in_cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    checks++;
    if ({bus1.add_a, bus1.add_b, bus1.add_cin, bus1.out_valid} !== {4'hF, 4'hF, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL n1 run a/b/cin/ov got %h/%h/%b/%b exp f/f/1/0", bus1.add_a, bus1.add_b, bus1.add_cin, bus1.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus1.out_valid, bus1.out_cout, bus1.out_sum} !== {1'b1, 1'b1, 4'hF}) begin
      errs++;
      $display("FAIL n1 result ov/cout/sum got %b/%b/%h exp 1/1/f", bus1.out_valid, bus1.out_cout, bus1.out_sum);
    end
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    checks++; if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1)
      begin errs++; $display("FAIL n1 handshake ov/ir got %b%b exp 01", bus1.out_valid, bus1.in_ready); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    int           hold, bad, t;
    for (int it = 0; it < 25; it++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      if (it == 0) begin a = 16'h8000; b = 16'h8000; c = 1'b0; end
      e = ref_add(a, b, c);
      hold = $urandom_range(0, 3);
      t = 0;
      while (bus4.in_ready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      checks++; if (bus4.in_ready !== 1'b1) begin errs++; $display("FAIL rnd%0d wait_ready timeout", it); end
      bus4.in_a = a; bus4.in_b = b; bus4.in_cin = c; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      bus4.in_valid = 1'b0;
      bad = 0;
      for (int k = 0; k < N; k++) begin
        if ({bus4.add_a, bus4.add_b, bus4.add_cin, bus4.out_valid} !==
            {nib(a, k), nib(b, k), ref_carry(a, b, c, k), 1'b0}) bad++;
        @(posedge clk); #1;
      end
      checks++; if (bad != 0) begin errs++; $display("FAIL rnd%0d slice_feed bad_cycles got %0d exp 0 (a=%h b=%h c=%b)", it, bad, a, b, c); end
      for (int h = 0; h <= hold; h++) begin
        checks++;
        if ({bus4.out_valid, bus4.in_ready, bus4.out_cout, bus4.out_sum} !== {2'b10, e}) begin
          errs++;
          $display("FAIL rnd%0d result%0d ov/ir/cout/sum got %b/%b/%b/%h exp 1/0/%b/%h", it, h,
                   bus4.out_valid, bus4.in_ready, bus4.out_cout, bus4.out_sum, e[W], e[W-1:0]);
        end
        if (h == hold) bus4.out_ready = 1'b1;
        @(posedge clk); #1;
      end
      bus4.out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_ignore_during_run();
    test_reset_mid_op();
    test_single_nibble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
